// File: rtl/regfile_operand_latch.sv
// Register file with per-register busy bits and two operand latches (A, B).
// A load stalls while its source has an outstanding claim. Loads of A and B are all-or-nothing.
module regfile_operand_latch #(
   parameter int WIDTH   = 16,
   parameter int DEPTH   = 8,
   parameter int ZERO_R0 = 0,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             write,
   input  logic [AW-1:0]    writenum,
   input  logic [WIDTH-1:0] data_in,
   input  logic             claim,
   input  logic [AW-1:0]    claimnum,
   input  logic [AW-1:0]    readnum_a,
   input  logic [AW-1:0]    readnum_b,
   input  logic             loada,
   input  logic             loadb,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic             stall
);

   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [WIDTH-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0] busy_q, busy_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic             wr_en_s, clm_en_s;
   logic             byp_a_s, byp_b_s, rdy_a_s, rdy_b_s, stall_s;
   logic [WIDTH-1:0] rd_a_s, rd_b_s;

   function automatic logic is_zero_reg(input logic [AW-1:0] idx);
      return (ZERO_R0 != 0) && (idx == {AW{1'b0}});
   endfunction

   // Operand read values, readiness and the shared stall decision
   always_comb begin
      wr_en_s  = write && !is_zero_reg(writenum);
      clm_en_s = claim && !is_zero_reg(claimnum);
      byp_a_s  = wr_en_s && (writenum == readnum_a);
      byp_b_s  = wr_en_s && (writenum == readnum_b);
      if (is_zero_reg(readnum_a)) begin
         rd_a_s = {WIDTH{1'b0}};
      end else if (byp_a_s) begin
         rd_a_s = data_in;
      end else begin
         rd_a_s = regs_q[readnum_a];
      end
      if (is_zero_reg(readnum_b)) begin
         rd_b_s = {WIDTH{1'b0}};
      end else if (byp_b_s) begin
         rd_b_s = data_in;
      end else begin
         rd_b_s = regs_q[readnum_b];
      end
      rdy_a_s = byp_a_s || !busy_q[readnum_a];
      rdy_b_s = byp_b_s || !busy_q[readnum_b];
      // rst_n gating keeps stall low while the block is held in reset
      stall_s = rst_n && ((loada && !rdy_a_s) || (loadb && !rdy_b_s));
   end

   // Next state: write clears busy, a same-cycle claim of that index re-sets it
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      a_d    = a_q;
      b_d    = b_q;
      if (wr_en_s) begin
         regs_d[writenum] = data_in;
         busy_d[writenum] = 1'b0;
      end else begin
         busy_d = busy_d;
      end
      if (clm_en_s) begin
         busy_d[claimnum] = 1'b1;
      end else begin
         busy_d = busy_d;
      end
      if (!stall_s) begin
         if (loada) begin
            a_d = rd_a_s;
         end else begin
            a_d = a_q;
         end
         if (loadb) begin
            b_d = rd_b_s;
         end else begin
            b_d = b_q;
         end
      end else begin
         a_d = a_q;
         b_d = b_q;
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= {WIDTH{1'b0}};
         end
         busy_q <= {DEPTH{1'b0}};
         a_q    <= {WIDTH{1'b0}};
         b_q    <= {WIDTH{1'b0}};
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
         a_q    <= a_d;
         b_q    <= b_d;
      end
   end

   assign A     = a_q;
   assign B     = b_q;
   assign stall = stall_s;

endmodule

// File: tb/tb_regfile_operand_latch.sv
// Scoreboard bench: two instances (ZERO_R0=0 and ZERO_R0=1) share stimulus; a rule-level
// model pushes expected stall / A / B per cycle, monitors pop and compare.
module tb_regfile_operand_latch;

   typedef struct {
      logic [15:0] a [2];
      logic [15:0] b [2];
      logic        st [2];
      string       nm;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        write = 1'b0, claim = 1'b0, loada = 1'b0, loadb = 1'b0;
   logic [2:0]  writenum = 3'd0, claimnum = 3'd0, readnum_a = 3'd0, readnum_b = 3'd0;
   logic [15:0] data_in = 16'h0000;
   logic [15:0] a0, b0, a1, b1;
   logic        stall0, stall1;

   int checks = 0;
   int errors = 0;

   exp_t st_q[$];
   exp_t ab_q[$];

   logic [15:0] m_reg  [2][8];
   bit          m_busy [2][8];
   logic [15:0] m_a [2];
   logic [15:0] m_b [2];

   regfile_operand_latch #(.WIDTH(16), .DEPTH(8), .ZERO_R0(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .write(write), .writenum(writenum), .data_in(data_in),
      .claim(claim), .claimnum(claimnum), .readnum_a(readnum_a), .readnum_b(readnum_b),
      .loada(loada), .loadb(loadb), .A(a0), .B(b0), .stall(stall0));

   regfile_operand_latch #(.WIDTH(16), .DEPTH(8), .ZERO_R0(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .write(write), .writenum(writenum), .data_in(data_in),
      .claim(claim), .claimnum(claimnum), .readnum_a(readnum_a), .readnum_b(readnum_b),
      .loada(loada), .loadb(loadb), .A(a1), .B(b1), .stall(stall1));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int z = 0; z < 2; z++) begin
         for (int i = 0; i < 8; i++) begin
            m_reg[z][i]  = 16'h0000;
            m_busy[z][i] = 1'b0;
         end
         m_a[z] = 16'h0000;
         m_b[z] = 16'h0000;
      end
   endtask

   // Apply one cycle of inputs, advance the model past the coming edge, queue expectations.
   task automatic drive(input string nm, input logic w, input logic [2:0] wn, input logic [15:0] d,
                        input logic c, input logic [2:0] cn, input logic [2:0] ra,
                        input logic [2:0] rb, input logic la, input logic lb);
      exp_t e;
      write = w; writenum = wn; data_in = d; claim = c; claimnum = cn;
      readnum_a = ra; readnum_b = rb; loada = la; loadb = lb;
      for (int z = 0; z < 2; z++) begin
         bit wr_ok, rdy_a, rdy_b, st;
         logic [15:0] va, vb;
         wr_ok = w && !(z == 1 && wn == 3'd0);
         va = (z == 1 && ra == 3'd0) ? 16'h0000 : ((wr_ok && wn == ra) ? d : m_reg[z][ra]);
         vb = (z == 1 && rb == 3'd0) ? 16'h0000 : ((wr_ok && wn == rb) ? d : m_reg[z][rb]);
         rdy_a = (wr_ok && wn == ra) || !m_busy[z][ra];
         rdy_b = (wr_ok && wn == rb) || !m_busy[z][rb];
         st = (la && !rdy_a) || (lb && !rdy_b);
         if (!st && la) m_a[z] = va;
         if (!st && lb) m_b[z] = vb;
         if (wr_ok) begin
            m_reg[z][wn]  = d;
            m_busy[z][wn] = 1'b0;
         end
         if (c && !(z == 1 && cn == 3'd0)) m_busy[z][cn] = 1'b1;
         e.st[z] = st;
         e.a[z]  = m_a[z];
         e.b[z]  = m_b[z];
      end
      e.nm = nm;
      st_q.push_back(e);
      ab_q.push_back(e);
   endtask

   task automatic idle(input string nm);
      drive(nm, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #3;
   endtask

   // Stall monitor: combinational output sampled mid-cycle
   initial begin
      forever begin
         @(negedge clk);
         if (st_q.size() > 0) begin
            exp_t e;
            e = st_q.pop_front();
            chk({e.nm, "_stall_z0"}, {15'd0, stall0}, {15'd0, e.st[0]});
            chk({e.nm, "_stall_z1"}, {15'd0, stall1}, {15'd0, e.st[1]});
         end
      end
   end

   // Operand monitor: registered outputs sampled just after the edge
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (ab_q.size() > 0) begin
            exp_t e;
            e = ab_q.pop_front();
            chk({e.nm, "_A_z0"}, a0, e.a[0]);
            chk({e.nm, "_B_z0"}, b0, e.b[0]);
            chk({e.nm, "_A_z1"}, a1, e.a[1]);
            chk({e.nm, "_B_z1"}, b1, e.b[1]);
         end
      end
   end

   initial begin
      model_reset();
      #12;
      chk("rst_A", a0, 16'h0000);
      chk("rst_B", b0, 16'h0000);
      chk("rst_stall", {15'd0, stall0}, 16'h0000);
      tick();
      rst_n = 1'b1;
      tick();

      // Write then read: A picks up reg3 one cycle after the load, B untouched
      drive("wr3", 1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0); tick();
      drive("ld3", 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd3, 3'd0, 1'b1, 1'b0); tick();
      chk("req21_A", a0, 16'h1234);
      chk("req21_B", b0, 16'h0000);

      // Write bypass into B
      drive("byp5", 1'b1, 3'd5, 16'hBEEF, 1'b0, 3'd0, 3'd0, 3'd5, 1'b0, 1'b1);
      #1 chk("req22_stall", {15'd0, stall0}, 16'h0000);
      tick();
      chk("req22_B", b0, 16'hBEEF);

      // Claim blocks the load until the producing write arrives
      drive("clm2", 1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 3'd2, 3'd0, 1'b1, 1'b0); tick();
      drive("blk2", 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd2, 3'd0, 1'b1, 1'b0);
      #1 chk("req23_stall", {15'd0, stall0}, 16'h0001);
      tick();
      chk("req23_hold", a0, 16'h0000);
      drive("wr2", 1'b1, 3'd2, 16'h00AA, 1'b0, 3'd0, 3'd2, 3'd0, 1'b1, 1'b0);
      #1 chk("req23_release", {15'd0, stall0}, 16'h0000);
      tick();
      chk("req23_A", a0, 16'h00AA);

      // All-or-nothing: one blocked source holds both latches
      drive("clm1", 1'b1, 3'd4, 16'h4444, 1'b1, 3'd1, 3'd0, 3'd0, 1'b0, 1'b0); tick();
      drive("aon", 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd1, 3'd4, 1'b1, 1'b1);
      #1 chk("req24_stall", {15'd0, stall0}, 16'h0001);
      tick();
      chk("req24_A", a0, 16'h00AA);
      chk("req24_B", b0, 16'hBEEF);

      // Claim/write collision: data stored, register stays busy
      drive("col6", 1'b1, 3'd6, 16'h5A5A, 1'b1, 3'd6, 3'd0, 3'd0, 1'b0, 1'b0); tick();
      drive("ld6", 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd6, 3'd6, 1'b1, 1'b1);
      #1 chk("req25_stall", {15'd0, stall0}, 16'h0001);
      tick();
      drive("wb6", 1'b1, 3'd6, 16'h6666, 1'b0, 3'd0, 3'd0, 3'd6, 1'b0, 1'b1); tick();
      drive("ld6b", 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd6, 3'd0, 1'b1, 1'b0); tick();
      chk("req25_A", a0, 16'h6666);

      // Claim in the same cycle as a load of that index does not block it
      drive("clmld", 1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 3'd3, 3'd3, 1'b1, 1'b1);
      #1 chk("req15_stall", {15'd0, stall0}, 16'h0000);
      tick();
      chk("req16_same", b0, 16'h1234);

      // Randomized traffic on both instances
      for (int n = 0; n < 400; n++) begin
         drive("rnd", ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)), 16'($urandom),
               ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
               3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0));
         tick();
      end

      // Async reset between edges with claims pending and latches loaded
      drive("prerst", 1'b1, 3'd7, 16'h7777, 1'b1, 3'd1, 3'd7, 3'd7, 1'b1, 1'b1); tick();
      claim = 1'b1; claimnum = 3'd5; loada = 1'b1; loadb = 1'b1; readnum_a = 3'd1;
      #1 rst_n = 1'b0;
      #1;
      chk("arst_A", a0, 16'h0000);
      chk("arst_B", b0, 16'h0000);
      chk("arst_stall", {15'd0, stall0}, 16'h0000);
      write = 1'b1; writenum = 3'd2; data_in = 16'hDEAD;
      tick();
      chk("inrst_A", a0, 16'h0000);
      chk("inrst_stall1", {15'd0, stall1}, 16'h0000);
      model_reset();
      write = 1'b0; claim = 1'b0; loada = 1'b0; loadb = 1'b0;
      rst_n = 1'b1;
      tick();

      // No claim survives reset; reg2 write during reset was ignored
      drive("post1", 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd1, 3'd2, 1'b1, 1'b1);
      #1 chk("req20_stall", {15'd0, stall0}, 16'h0000);
      tick();
      chk("req20_B", b0, 16'h0000);

      // Hard-wired zero register on the ZERO_R0 instance
      drive("wr0", 1'b1, 3'd0, 16'hFFFF, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1); tick();
      chk("z1_byp0", b1, 16'h0000);
      chk("z0_byp0", b0, 16'hFFFF);
      drive("ld0", 1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0); tick();
      chk("req26_A_z1", a1, 16'h0000);
      drive("ld0b", 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0);
      #1 chk("z1_busy0", {15'd0, stall1}, 16'h0000);
      tick();
      idle("drain"); tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
